// File: rtl/maxnet_pkg.sv
// Constants and state encoding for the Maxnet datapath and its controller.
package maxnet_pkg;

  localparam int MAXNET_WIDTH    = 5;
  localparam int MAXNET_MAX_ITER = 31;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_EVAL   = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;

  // Smallest counter width that can hold the value n (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/maxnet_iter_counter.sv
// Saturating iteration counter: synchronous clear, increment, terminal-count flag.
// Clear wins over increment; the count holds at MAX_ITER instead of wrapping.
module maxnet_iter_counter
  import maxnet_pkg::*;
#(
  parameter int ITER_W   = 5,
  parameter int MAX_ITER = MAXNET_MAX_ITER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ITER_W-1:0] count,
  output logic              at_max
);

  assign at_max = (count == ITER_W'(MAX_ITER));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + ITER_W'(1);
    end
  end

endmodule

// File: rtl/maxnet_controller.sv
// Sequences the Maxnet datapath: holds one accepted vector, issues the initial and
// iteration loads until done or MAX_ITER, then presents the result until taken.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int WIDTH    = MAXNET_WIDTH,
  parameter int MAX_ITER = MAXNET_MAX_ITER,
  parameter int ITER_W   = 5,
  parameter int PU_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_x1,
  input  logic [WIDTH-1:0]  in_x2,
  input  logic [WIDTH-1:0]  in_x3,
  input  logic [WIDTH-1:0]  in_x4,
  output logic [WIDTH-1:0]  dp_x1,
  output logic [WIDTH-1:0]  dp_x2,
  output logic [WIDTH-1:0]  dp_x3,
  output logic [WIDTH-1:0]  dp_x4,
  output logic              dp_sel_t,
  output logic              dp_ld_t,
  input  logic              dp_done,
  input  logic [31:0]       dp_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  res_max,
  output logic [ITER_W-1:0] res_iter,
  output logic              res_timeout
);

  localparam int WAIT_W = cnt_width(PU_LAT);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ITER_W-1:0] iter_cnt;
  logic              iter_at_max;
  logic              accept;
  logic              eval_step;
  logic              unused_dp_max;

  // Only the low WIDTH bits of the datapath maximum carry a value.
  assign unused_dp_max = ^dp_max[31:WIDTH];

  assign accept    = (state == ST_IDLE) && in_valid;
  assign eval_step = (state == ST_EVAL) && !dp_done && !iter_at_max;

  // Load strobes are decoded from state so reset drops them immediately.
  assign in_ready  = (state == ST_IDLE);
  assign dp_sel_t  = (state == ST_INIT);
  assign dp_ld_t   = dp_sel_t || eval_step;
  assign out_valid = (state == ST_RESULT);
  assign res_iter  = iter_cnt;

  maxnet_iter_counter #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .inc    (eval_step),
    .count  (iter_cnt),
    .at_max (iter_at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      dp_x1       <= '0;
      dp_x2       <= '0;
      dp_x3       <= '0;
      dp_x4       <= '0;
      wait_cnt    <= '0;
      res_max     <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            dp_x1 <= in_x1;
            dp_x2 <= in_x2;
            dp_x3 <= in_x3;
            dp_x4 <= in_x4;
            state <= ST_INIT;
          end
        end
        ST_INIT: begin
          wait_cnt <= WAIT_W'(PU_LAT);
          state    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Leaves after PU_LAT idle clocks so done/max are valid in EVAL.
          wait_cnt <= wait_cnt - WAIT_W'(1);
          if (wait_cnt == WAIT_W'(1)) begin
            state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (dp_done) begin
            res_max     <= dp_max[WIDTH-1:0];
            res_timeout <= 1'b0;
            state       <= ST_RESULT;
          end else if (iter_at_max) begin
            res_max     <= '0;
            res_timeout <= 1'b1;
            state       <= ST_RESULT;
          end else begin
            wait_cnt <= WAIT_W'(PU_LAT);
            state    <= ST_SETTLE;
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/maxnet_controller.md
Name: maxnet_controller

Overview:
- Control-side counterpart of the Maxnet datapath. Accepts one vector X1..X4 from upstream over a valid/ready handshake and holds it stable on the datapath inputs.
- Drives the datapath's sel_t/ld_t sequence: an initial load, then repeated iteration loads until the datapath's done is seen or an iteration limit is reached.
- Returns the winning value, the iteration count and a timeout flag downstream over a second valid/ready handshake.

Parameters:
- WIDTH, 5, bit width of each input value X1..X4.
- MAX_ITER, 31, maximum iteration loads before the run is abandoned with a timeout.
- ITER_W, 5, width of the iteration counter; must satisfy 2**ITER_W > MAX_ITER.
- PU_LAT, 1, number of clocks the datapath needs between a ld_t pulse and a valid done/maximum_number; minimum 1.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst  in  1  Reset, asynchronous, active-low.
- in_valid  in  1  Upstream has a vector on in_x1..in_x4.
- in_ready  out  1  Controller can accept a vector.
- in_x1..in_x4  in  WIDTH each  Input vector.
- dp_x1..dp_x4  out  WIDTH each  Registered copy of the accepted vector; drives datapath X1..X4.
- dp_sel_t  out  1  Datapath mux select: 1 = load X, 0 = load activation outputs.
- dp_ld_t  out  1  Datapath temp-register load enable.
- dp_done  in  1  Datapath reports exactly one nonzero temp value.
- dp_max  in  32  Datapath maximum_number.
- out_valid  out  1  A result is available.
- out_ready  in  1  Downstream accepts the result.
- res_max  out  WIDTH  Winning value, taken from dp_max[WIDTH-1:0]; 0 on timeout.
- res_iter  out  ITER_W  Number of iteration loads performed, not counting the initial load.
- res_timeout  out  1  1 = MAX_ITER reached without dp_done.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - dp_x*, res_max, res_iter, iteration counter and wait counter = 0.
  - dp_ld_t = 0, dp_sel_t = 0, out_valid = 0, res_timeout = 0.
  - Reset is honoured mid-run: the run is discarded and no result is produced.
- States:
  - IDLE: in_ready=1. When in_valid=1, capture in_x1..in_x4 into dp_x1..dp_x4, clear the iteration counter, go to INIT.
  - INIT: exactly one cycle with dp_sel_t=1 and dp_ld_t=1. Load wait counter with PU_LAT, go to SETTLE.
  - SETTLE: dp_ld_t=0. Decrement the wait counter; go to EVAL when it reaches 0 (PU_LAT idle clocks).
  - EVAL (one cycle):
    - dp_done=1: res_max <= dp_max[WIDTH-1:0], res_timeout <= 0, go to RESULT.
    - Else, iteration counter == MAX_ITER: res_max <= 0, res_timeout <= 1, go to RESULT.
    - Else: dp_ld_t=1, dp_sel_t=0 in this cycle, increment the iteration counter, reload the wait counter, go to SETTLE.
    - dp_done takes priority over timeout when both conditions hold in the same cycle.
  - RESULT: out_valid=1, with res_iter = iteration counter and res_max/res_timeout stable. When out_ready=1, go to IDLE and drop out_valid the next cycle.
- in_ready is 1 only in IDLE. in_valid outside IDLE is ignored and nothing is captured.
- dp_x* are held constant from capture until the next capture.
- dp_ld_t is never high for two consecutive cycles. dp_sel_t=1 only in INIT.
- Latency from accept to out_valid: 1 + (PU_LAT+1)·(n+1) clocks, where n is the number of iteration loads.
- All-zero or tied inputs never raise dp_done, so they end in a timeout with res_iter=MAX_ITER.
- The iteration counter saturates logic-wise at MAX_ITER and never wraps.
- Same-cycle in_valid and out_ready in RESULT: the result is handed off, and the new vector is accepted on a later cycle in IDLE (no bypass).

Decomposition:
- Shared package maxnet_pkg:
  - State enum {IDLE, INIT, SETTLE, EVAL, RESULT}.
  - Default constants MAXNET_WIDTH=5 and MAXNET_MAX_ITER=31.
  - These same constants are used by the datapath.
- One natural sub-module, maxnet_iter_counter: the iteration counter with clear, increment, saturation and terminal-count flag.

Test Plan:
- Bench uses a datapath stub that raises dp_done after a programmable number of iteration loads, with PU_LAT=1.
- Winner found: X=(3,7,2,5), stub done after 3 iteration loads with dp_max=7 -> out_valid with res_max=7, res_iter=3, res_timeout=0; accept-to-out_valid = 9 clocks.
- Timeout: stub never raises done -> res_timeout=1, res_max=0, res_iter=31; exactly 32 dp_ld_t pulses seen (1 with sel_t=1, 31 with sel_t=0).
- Backpressure: out_ready held low 5 cycles in RESULT -> out_valid and res_* stable throughout; in_ready=0; in_valid pulses during the run and the stall do not change dp_x*.
- Immediate done: dp_done=1 at the first EVAL, dp_max=9 -> res_max=9, res_iter=0, only one dp_ld_t pulse.
- Reset mid-run: rst low during SETTLE of iteration 2 -> dp_ld_t=0, out_valid=0, dp_x*=0 immediately (asynchronous); after release in_ready=1 and a fresh run completes normally.
